// File: rtl/pcap_wr_ctrl.sv
// pcap_wr_ctrl: packet-capture write controller.
// Writes an optional 4-word pcap record header (seconds, nanoseconds, len, len)
// followed by ceil(len/4) packet words from a show-ahead FIFO into a circular
// capture buffer over an Avalon-MM bursting master. Bursts never cross the
// buffer end; the write cursor wraps to the buffer base there.
// Build option: define PCAP_WR_CTRL_HDR_EN to emit the record header.
// Without it only data words are written and the timestamp is not latched.
module pcap_wr_ctrl #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic [31:0] control,
    input  logic [31:0] pkt_begin,
    input  logic [31:0] pkt_end,
    input  logic [31:0] capt_buf_start,
    input  logic [31:0] capt_buf_size,
    input  logic [31:0] last_write_addr_in,
    input  logic        empty,
    input  logic [8:0]  usedw,
    input  logic [31:0] fifo_out,
    output logic        rd_from_fifo,
    input  logic [31:0] seconds,
    input  logic [31:0] nanoseconds,
    output logic        wr_ctrl_rdy,
    output logic [31:0] last_write_addr_out,
    output logic        capt_buf_wrap,
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic        write,
    output logic [15:0] burstcount,
    input  logic        waitrequest
);

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA_WAIT,
        S_DATA_BURST,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;        // byte address of the next beat to write
    logic [31:0] buf_start_q;
    logic [31:0] buf_end_q;
    logic [31:0] words_rem_q;   // data words still to write
    logic [15:0] beats_q;       // beats left in the current burst
    logic        write_q;
    logic [31:0] address_q;
    logic [15:0] burstcount_q;
    logic        wrap_q;
    logic [31:0] last_addr_q;
    logic        rdy_q;

`ifdef PCAP_WR_CTRL_HDR_EN
    logic [31:0] sec_q;
    logic [31:0] nsec_q;
    logic [31:0] len_q;
    logic [2:0]  hdr_cnt_q;     // header words already accepted
    logic [31:0] hdr_word;
`endif

    logic [31:0] len_w;
    logic [31:0] start_w;
    logic [31:0] nwords_w;
    logic [31:0] to_end_w;
    logic [31:0] rem_w;
    logic [31:0] n_w;
    logic [31:0] addr_inc_w;
    logic [31:0] addr_next_w;
    logic        wrap_now_w;
    logic        accept_w;
    logic        unused_ok;

`ifdef PCAP_WR_CTRL_HDR_EN
    assign unused_ok = ^control;
`else
    assign unused_ok = ^{control, seconds, nanoseconds};
`endif

    // Record setup values, burst sizing and the wrapping write cursor.
    always_comb begin
        len_w    = pkt_end - pkt_begin;
        // A stale/out-of-range host pointer restarts the buffer at its base.
        start_w  = ((last_write_addr_in - capt_buf_start) < capt_buf_size) ?
                   last_write_addr_in : capt_buf_start;
        nwords_w = {2'b00, len_w[31:2]} + {31'd0, |len_w[1:0]};
        to_end_w = (buf_end_q - addr_q) >> 2;
`ifdef PCAP_WR_CTRL_HDR_EN
        rem_w    = (state_q == S_HDR) ? {29'd0, 3'd4 - hdr_cnt_q} : words_rem_q;
`else
        rem_w    = words_rem_q;
`endif
        n_w = rem_w;
        if (to_end_w < n_w)    n_w = to_end_w;
        if (MAX_BURST_W < n_w) n_w = MAX_BURST_W;
        addr_inc_w  = addr_q + 32'd4;
        wrap_now_w  = (addr_inc_w == buf_end_q);
        addr_next_w = wrap_now_w ? buf_start_q : addr_inc_w;
        accept_w    = write_q && !waitrequest;
    end

`ifdef PCAP_WR_CTRL_HDR_EN
    // Header word for the current header beat; constant while the beat stalls.
    always_comb begin
        case (hdr_cnt_q)
            3'd0:    hdr_word = sec_q;
            3'd1:    hdr_word = nsec_q;
            default: hdr_word = len_q;
        endcase
    end
    assign writedata = (state_q == S_DATA_BURST) ? fifo_out :
                       (state_q == S_HDR)        ? hdr_word : 32'd0;
`else
    assign writedata = (state_q == S_DATA_BURST) ? fifo_out : 32'd0;
`endif

    // Pop exactly when a data beat is taken by the interconnect.
    assign rd_from_fifo        = (state_q == S_DATA_BURST) && accept_w;
    assign write               = write_q;
    assign address             = address_q;
    assign burstcount          = burstcount_q;
    assign capt_buf_wrap       = wrap_q;
    assign last_write_addr_out = last_addr_q;
    assign wr_ctrl_rdy         = rdy_q;

    // Record sequencer: header, data bursts gated on FIFO fill, then report.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            buf_start_q  <= 32'd0;
            buf_end_q    <= 32'd0;
            words_rem_q  <= 32'd0;
            beats_q      <= 16'd0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            burstcount_q <= 16'd0;
            wrap_q       <= 1'b0;
            last_addr_q  <= 32'd0;
            rdy_q        <= 1'b1;
`ifdef PCAP_WR_CTRL_HDR_EN
            sec_q        <= 32'd0;
            nsec_q       <= 32'd0;
            len_q        <= 32'd0;
            hdr_cnt_q    <= 3'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_ctrl) begin
                        rdy_q       <= 1'b0;
                        wrap_q      <= 1'b0;
                        addr_q      <= start_w;
                        buf_start_q <= capt_buf_start;
                        buf_end_q   <= capt_buf_start + capt_buf_size;
                        words_rem_q <= nwords_w;
`ifdef PCAP_WR_CTRL_HDR_EN
                        sec_q       <= seconds;
                        nsec_q      <= nanoseconds;
                        len_q       <= len_w;
                        hdr_cnt_q   <= 3'd0;
                        state_q     <= S_HDR;
`else
                        state_q     <= (nwords_w == 32'd0) ? S_DONE : S_DATA_WAIT;
`endif
                    end
                end
`ifdef PCAP_WR_CTRL_HDR_EN
                S_HDR: begin
                    if (!write_q) begin
                        // Header words are always available, so issue at once.
                        write_q      <= 1'b1;
                        address_q    <= addr_q;
                        burstcount_q <= n_w[15:0];
                        beats_q      <= n_w[15:0];
                    end else if (!waitrequest) begin
                        addr_q    <= addr_next_w;
                        if (wrap_now_w) wrap_q <= 1'b1;
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        beats_q   <= beats_q - 16'd1;
                        if (beats_q == 16'd1) begin
                            write_q <= 1'b0;
                            if (hdr_cnt_q == 3'd3)
                                state_q <= (words_rem_q == 32'd0) ? S_DONE : S_DATA_WAIT;
                        end
                    end
                end
`endif
                S_DATA_WAIT: begin
                    // Only start a burst the FIFO can feed without gaps.
                    if (!empty && ({23'd0, usedw} >= n_w)) begin
                        write_q      <= 1'b1;
                        address_q    <= addr_q;
                        burstcount_q <= n_w[15:0];
                        beats_q      <= n_w[15:0];
                        state_q      <= S_DATA_BURST;
                    end
                end
                S_DATA_BURST: begin
                    if (accept_w) begin
                        addr_q      <= addr_next_w;
                        if (wrap_now_w) wrap_q <= 1'b1;
                        words_rem_q <= words_rem_q - 32'd1;
                        beats_q     <= beats_q - 16'd1;
                        if (beats_q == 16'd1) begin
                            write_q <= 1'b0;
                            state_q <= (words_rem_q == 32'd1) ? S_DONE : S_DATA_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    last_addr_q <= addr_q;
                    rdy_q       <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcap_wr_ctrl.sv
// Directed bench for pcap_wr_ctrl: table of records plus reset sequences.
// Works for both builds; expected header words/addresses follow the build.
module tb_pcap_wr_ctrl;

    localparam int          MAXB   = 8;
    localparam logic [31:0] BSTART = 32'h8000;
    localparam logic [31:0] BSIZE  = 32'h80;
`ifdef PCAP_WR_CTRL_HDR_EN
    localparam int HDRW = 4;
`else
    localparam int HDRW = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_ctrl = 1'b0;
    logic [31:0] control = 32'd0;
    logic [31:0] pkt_begin = 32'd0, pkt_end = 32'd0;
    logic [31:0] capt_buf_start = 32'd0, capt_buf_size = 32'd0;
    logic [31:0] last_write_addr_in = 32'd0;
    logic        empty = 1'b1;
    logic [8:0]  usedw = 9'd0;
    logic [31:0] fifo_out = 32'd0;
    logic        rd_from_fifo;
    logic [31:0] seconds = 32'd0, nanoseconds = 32'd0;
    logic        wr_ctrl_rdy;
    logic [31:0] last_write_addr_out;
    logic        capt_buf_wrap;
    logic [31:0] address, writedata;
    logic        write;
    logic [15:0] burstcount;
    logic        waitrequest = 1'b0;

    pcap_wr_ctrl #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .control(control),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end),
        .capt_buf_start(capt_buf_start), .capt_buf_size(capt_buf_size),
        .last_write_addr_in(last_write_addr_in),
        .empty(empty), .usedw(usedw), .fifo_out(fifo_out), .rd_from_fifo(rd_from_fifo),
        .seconds(seconds), .nanoseconds(nanoseconds),
        .wr_ctrl_rdy(wr_ctrl_rdy), .last_write_addr_out(last_write_addr_out),
        .capt_buf_wrap(capt_buf_wrap),
        .address(address), .writedata(writedata), .write(write),
        .burstcount(burstcount), .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    // mode: 0 = FIFO preloaded, 1 = waitrequest toggles, 2 = FIFO starved
    typedef struct {
        logic [31:0] pb, pe, lin, exp_h, exp_d;
        logic        wrap;
        int          mode;
    } vec_t;
    vec_t vt[8];

    int          checks = 0, errors = 0;
    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    int          cyc, nbeats, npops, beats_left, first_wr, mode;
    logic        refilled, prev_stall;
    logic [31:0] cur, burst_addr, refill_base, nwords, p_addr, p_wd;
    logic [15:0] burst_bc, p_bc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic upd_fifo();
        empty    = (fq.size() == 0);
        usedw    = (fq.size() > 511) ? 9'd511 : 9'(fq.size());
        fifo_out = (fq.size() > 0) ? fq[0] : 32'hDEAD_BEEF;
    endtask

    // One clock: drive waitrequest/FIFO at negedge, sample 1 ns later.
    task automatic cycle();
        logic acc;
        @(negedge clk);
        waitrequest = (mode == 1) ? (cyc % 2 == 0) : 1'b0;
        if (mode == 2 && !refilled && cyc == 20) begin
            for (int i = 3; i < int'(nwords); i++) fq.push_back(refill_base + 32'(i));
            refilled = 1'b1;
        end
        upd_fifo();
        #1;
        if (prev_stall) begin
            check("stall_write", write, 1);
            check("stall_address", address, p_addr);
            check("stall_burstcount", burstcount, p_bc);
            check("stall_writedata", writedata, p_wd);
        end
        prev_stall = write && waitrequest;
        p_addr = address; p_bc = burstcount; p_wd = writedata;
        if (write && first_wr < 0) first_wr = cyc;
        if (mode == 2 && !refilled && nbeats >= HDRW) check("starve_no_write", write, 0);
        acc = write && !waitrequest;
        check("rd_from_fifo", rd_from_fifo, acc && (nbeats >= HDRW));
        if (acc) begin
            if (beats_left == 0) begin
                check("burst_start_addr", address, cur);
                check("burst_len_range", (burstcount >= 16'd1) && (burstcount <= 16'(MAXB)), 1);
                check("burst_no_cross", (address + {14'd0, burstcount, 2'b00}) <= (BSTART + BSIZE), 1);
                beats_left = int'(burstcount);
                burst_addr = address;
                burst_bc   = burstcount;
            end else begin
                check("burst_addr_hold", address, burst_addr);
                check("burst_bc_hold", burstcount, burst_bc);
            end
            if (nbeats < exp_q.size()) check("beat_data", writedata, exp_q[nbeats]);
            else check("extra_beat", nbeats, exp_q.size());
            cur = cur + 32'd4;
            if (cur == BSTART + BSIZE) cur = BSTART;
            beats_left--;
            nbeats++;
        end
        if (rd_from_fifo) begin
            npops++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        upd_fifo();
        cyc++;
    endtask

    task automatic start_rec(input int v);
        logic [31:0] len;
        int pre;
        @(negedge clk);
        mode               = vt[v].mode;
        pkt_begin          = vt[v].pb;
        pkt_end            = vt[v].pe;
        last_write_addr_in = vt[v].lin;
        capt_buf_start     = BSTART;
        capt_buf_size      = BSIZE;
        seconds            = 32'h5EC0_0000 + 32'(v);
        nanoseconds        = 32'h0001_0000 + 32'(v);
        len                = vt[v].pe - vt[v].pb;
        nwords             = len / 4 + ((len % 4 != 0) ? 32'd1 : 32'd0);
        refill_base        = 32'd10 + 32'(100 * v);
        fq.delete();
        exp_q.delete();
        if (HDRW != 0) begin
            exp_q.push_back(seconds); exp_q.push_back(nanoseconds);
            exp_q.push_back(len);     exp_q.push_back(len);
        end
        for (int i = 0; i < int'(nwords); i++) exp_q.push_back(refill_base + 32'(i));
        pre = (mode == 2 && nwords > 3) ? 3 : int'(nwords);
        for (int i = 0; i < pre; i++) fq.push_back(refill_base + 32'(i));
        cur = ((vt[v].lin - BSTART) < BSIZE) ? vt[v].lin : BSTART;
        cyc = 0; nbeats = 0; npops = 0; beats_left = 0; first_wr = -1;
        refilled = 1'b0; prev_stall = 1'b0;
        waitrequest = 1'b0;
        wr_ctrl = 1'b1;
        upd_fifo();
        @(negedge clk);
        wr_ctrl = 1'b0;
        // Timestamp must have been captured at the start pulse.
        seconds = ~seconds;
        nanoseconds = ~nanoseconds;
        #1;
        check("rdy_low_after_start", wr_ctrl_rdy, 0);
        check("no_write_at_start", write, 0);
    endtask

    task automatic run_vec(input int v);
        bit done;
        done = 1'b0;
        start_rec(v);
        for (int i = 0; i < 3000 && !done; i++) begin
            cycle();
            if (wr_ctrl_rdy) done = 1'b1;
        end
        check("record_done", done, 1);
        check("beat_count", nbeats, exp_q.size());
        check("pop_count", npops, nwords);
        check("fifo_drained", fq.size(), 0);
`ifdef PCAP_WR_CTRL_HDR_EN
        check("last_write_addr_out", last_write_addr_out, vt[v].exp_h);
`else
        check("last_write_addr_out", last_write_addr_out, vt[v].exp_d);
`endif
        check("capt_buf_wrap", capt_buf_wrap, vt[v].wrap);
        if (mode == 0 && exp_q.size() > 0) check("first_write_latency", first_wr >= 0 && first_wr <= 1, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, write, 0);
        check({tag, "_rd_from_fifo"}, rd_from_fifo, 0);
        check({tag, "_capt_buf_wrap"}, capt_buf_wrap, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_writedata"}, writedata, 0);
        check({tag, "_burstcount"}, burstcount, 0);
        check({tag, "_last_write_addr_out"}, last_write_addr_out, 0);
        check({tag, "_wr_ctrl_rdy"}, wr_ctrl_rdy, 1);
    endtask

    initial begin
        //        pb            pe      lin      exp_h    exp_d    wrap mode
        vt[0] = '{32'h0,        32'hF2,  32'h8000, 32'h8004, 32'h8074, 1'b1, 0}; // wrap twice
        vt[1] = '{32'h0,        32'hF2,  32'h8004, 32'h8008, 32'h8078, 1'b1, 0}; // back-to-back
        vt[2] = '{32'h0,        32'hF2,  32'h8000, 32'h8004, 32'h8074, 1'b1, 1}; // stalls
        vt[3] = '{32'h100,      32'h100, 32'h8010, 32'h8020, 32'h8010, 1'b0, 0}; // zero length
        vt[4] = '{32'h4,        32'h10,  32'h9000, 32'h801C, 32'h800C, 1'b0, 0}; // bad ptr -> base
        vt[5] = '{32'h0,        32'h5,   32'h8078, 32'h8010, 32'h8000, 1'b1, 0}; // split at end, pad
        vt[6] = '{32'h0,        32'h50,  32'h8000, 32'h8060, 32'h8050, 1'b0, 2}; // starvation
        vt[7] = '{32'hFFFF_FFF8, 32'h8,  32'h8040, 32'h8060, 32'h8050, 1'b0, 0}; // len mod 2^32

        mode = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) run_vec(v);

        // Reset in the middle of a record abandons it immediately.
        start_rec(0);
        repeat (20) cycle();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        fq.delete();
        upd_fifo();
        run_vec(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcap_wr_ctrl.md
# pcap_wr_ctrl

Packet-capture write controller. It sits between the packet-data FIFO and an Avalon-MM bursting write master port into a circular capture buffer in memory. On a `wr_ctrl` pulse it writes a 4-word pcap record header (timestamp plus lengths), then drains the packet words from the FIFO. It wraps addresses inside the buffer and reports the next free address back to the host/CSR block.

## Interface
- `MAX_BURST`, 8: maximum Avalon burst length in 32-bit words (1..255).
- `clk` in 1: system clock.
- `reset` in 1: one clock domain; reset is asynchronous and active-low.
- `wr_ctrl` in 1: start pulse; sampled only when `wr_ctrl_rdy`=1.
- `control` in 32: reserved, ignored.
- `pkt_begin`, `pkt_end` in 32: byte offsets; packet length `len = pkt_end - pkt_begin` (mod 2^32).
- `capt_buf_start`, `capt_buf_size` in 32: buffer base byte address and size (word-aligned, size ≥ 16).
- `last_write_addr_in` in 32: byte address where this record starts.
- `empty` in 1, `usedw` in 9, `fifo_out` in 32: show-ahead FIFO status and head word.
- `rd_from_fifo` out 1: FIFO pop.
- `seconds`, `nanoseconds` in 32: free-running timestamp.
- `wr_ctrl_rdy` out 1: idle, ready for `wr_ctrl`.
- `last_write_addr_out` out 32: next free byte address after the last record.
- `capt_buf_wrap` out 1: the last/current record wrapped the buffer.
- `address` out 32, `writedata` out 32, `write` out 1, `burstcount` out 16, `waitrequest` in 1: Avalon-MM master.

## Operation
- States: IDLE → HDR → DATA_WAIT ⇄ DATA_BURST → DONE → IDLE.
- IDLE: `wr_ctrl_rdy`=1. When `wr_ctrl`=1, latch `len`, `seconds`, `nanoseconds`, and the start address, then clear `capt_buf_wrap`.
  - The start address is `last_write_addr_in`. If `last_write_addr_in` is outside [start, start+size), `capt_buf_start` is used instead.
- HDR: write words in this order: `seconds`, `nanoseconds`, `len`, `len` (incl_len = orig_len).
- Data word count is `N = ceil(len/4)`; the last word is written whole (padding bytes come from the FIFO word).
- DATA_WAIT: compute `n = min(MAX_BURST, words remaining, words to buffer end)`. Go to DATA_BURST once `usedw ≥ n` and `empty`=0.
- DATA_BURST: each data beat uses `writedata = fifo_out`, and `rd_from_fifo` = that beat is accepted.
- Beat acceptance: a beat is accepted when `write && !waitrequest`. `write`, `address`, `burstcount` and `writedata` hold until the beat is accepted.
- Bursts:
  - `address` is the burst start byte address, constant for the whole burst.
  - `burstcount` is in words.
  - A burst never crosses `capt_buf_start+capt_buf_size`.
  - The header is also split at the buffer end.
- Wrap: the next address at buffer end is `capt_buf_start`, and `capt_buf_wrap` is set to 1. It stays set until the next accepted `wr_ctrl`.
- DONE: `last_write_addr_out` ← next free address (wrapped), then return to IDLE. `len`=0 writes the header only.
- `wr_ctrl` outside IDLE is ignored. There is no abort; only reset stops a record.

## Timing
- Reset values:
  - `write`, `rd_from_fifo`, `capt_buf_wrap` = 0.
  - `address`, `writedata`, `burstcount`, `last_write_addr_out` = 0.
  - `wr_ctrl_rdy` = 1.
  - State = IDLE.
- Reset mid-record abandons the record; no FIFO flush.
- `wr_ctrl` sampled at edge k: `wr_ctrl_rdy`=0 from k+1, and the first header `write` is asserted at k+1 or k+2.
- With `waitrequest`=0: one beat per cycle inside a burst, and at most 1 idle cycle between bursts.
- A record completes in `4+N` accepted beats plus burst overhead. `wr_ctrl_rdy` returns to 1 the cycle after DONE.
- `rd_from_fifo` is combinational with data-beat acceptance, so exactly N pops occur per record.

## Configuration
- `PCAP_WR_CTRL_HDR_EN` defined: the 4-word header is written as above.
- `PCAP_WR_CTRL_HDR_EN` undefined:
  - HDR is skipped and only data words are written; the timestamp is not latched.
  - `len`=0 goes straight to DONE with no writes, and `last_write_addr_out` = start address.

## Test plan
- Wrap with header: start 0x8000, size 0x80, last_write_addr_in 0x8000, pkt 0..0xF2, FIFO 10,11,…
  - Header words: seconds, nanoseconds, 0xF2, 0xF2. Data words: 10..70 (61 words).
  - No burst longer than 8 words and no burst crossing 0x8080.
  - `capt_buf_wrap`=1, `last_write_addr_out`=0x8004.
- Back-to-back: after `wr_ctrl_rdy` rises, repeat the same packet with `last_write_addr_in`=0x8004 → `last_write_addr_out`=0x8008.
- Stall: `waitrequest` toggling 1/0 per beat → no beat lost or duplicated, exactly 61 pops, and signals stable while stalled.
- FIFO starvation: only 3 words present with 8 needed → no `write` until `usedw` ≥ 8, then data is in order.
- Zero length: pkt_end=pkt_begin → 4 header beats (len=0), 0 pops, address advances by 16.
- Reset mid-burst: `reset`=0 → all outputs return to reset values immediately and `wr_ctrl_rdy`=1.
